// File: rtl/soc_multi_timer_if.sv
// -----------------------------------------------------------------------------
// soc_multi_timer_if
// Avalon-MM slave bundle shared by every channel of soc_multi_timer.
//
// Signals:
//   address    word address: [ADDR_W-1:2] = channel, [1:0] = register
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit registered read data (one-cycle latency)
//
// Modports:
//   master  drives the command side and receives readdata (CPU / bench)
//   slave   receives the command side and returns readdata (timer)
// -----------------------------------------------------------------------------
interface soc_multi_timer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_multi_timer.sv
// -----------------------------------------------------------------------------
// soc_multi_timer
// NUM_CH independent interval down-counters behind one Avalon-MM slave port.
// Each channel has a period, one-shot/continuous mode, software start/stop,
// a counter snapshot and its own interrupt; irq_any ORs all interrupts.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   s1       Avalon-MM slave (soc_multi_timer_if.slave)
//   irq      per-channel interrupt, TO & ITO
//   irq_any  OR of irq
//
// Per-channel register map (address[1:0]):
//   0 STATUS   read {RUN, TO}; any write clears TO
//   1 CONTROL  bit0 ITO, bit1 CONT, bit2 START, bit3 STOP
//   2 PERIOD   period; a write also reloads the counter and stops the channel
//   3 SNAP     any write captures the counter; read returns the snapshot
//
// Build option:
//   SOC_MULTI_TIMER_PRESCALE_EN  adds an 8-bit per-channel prescaler held in
//   CONTROL[15:8]; one counter tick every PRESCALE+1 clocks. Without it
//   CONTROL[15:8] reads 0 and the counter ticks every clock.
// -----------------------------------------------------------------------------
module soc_multi_timer #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 99999,
    parameter int ADDR_W         = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    soc_multi_timer_if.slave      s1,
    output logic [NUM_CH-1:0]     irq,
    output logic                  irq_any
);

    localparam logic [CNT_W-1:0] DEF_CNT     = CNT_W'(DEFAULT_PERIOD);
    localparam logic [1:0]       REG_STATUS  = 2'd0;
    localparam logic [1:0]       REG_CONTROL = 2'd1;
    localparam logic [1:0]       REG_PERIOD  = 2'd2;
    localparam logic [1:0]       REG_SNAP    = 2'd3;
    localparam int               CTRL_ITO    = 0;
    localparam int               CTRL_CONT   = 1;
    localparam int               CTRL_START  = 2;
    localparam int               CTRL_STOP   = 3;

    logic [3:0]        ctrl_q   [NUM_CH];
    logic [3:0]        ctrl_d   [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  snap_q   [NUM_CH];
    logic [CNT_W-1:0]  snap_d   [NUM_CH];
    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] zero_q, zero_d;
    logic [31:0]       readData_q, readData_d;

    logic [31:0]       chanIdx;
    logic [1:0]        regSel;
    logic              chanValid;
    logic              wrEn;
    logic [NUM_CH-1:0] chSel;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] timeout;
    logic [7:0]        pscRd    [NUM_CH];

    // writedata bits above the implemented fields are intentionally ignored
    logic unusedWrBits;
    assign unusedWrBits = ^s1.writedata;

    // Address decode; channels at or above NUM_CH never see a write
    always_comb begin
        chanIdx   = 32'(s1.address[ADDR_W-1:2]);
        regSel    = s1.address[1:0];
        chanValid = (chanIdx < 32'(NUM_CH));
        wrEn      = s1.chipselect && !s1.write_n && chanValid;
        for (int i = 0; i < NUM_CH; i++) begin
            chSel[i] = wrEn && (chanIdx == 32'(i));
        end
    end

`ifdef SOC_MULTI_TIMER_PRESCALE_EN
    logic [7:0] psc_q    [NUM_CH];
    logic [7:0] psc_d    [NUM_CH];
    logic [7:0] pscCnt_q [NUM_CH];
    logic [7:0] pscCnt_d [NUM_CH];

    // Prescaler: a tick fires when the prescale counter reaches PRESCALE,
    // and the counter restarts from 0 on START or a PERIOD write so the
    // first interval after either is a full one
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            psc_d[i]    = psc_q[i];
            pscCnt_d[i] = pscCnt_q[i];
            pscRd[i]    = psc_q[i];
            tick[i]     = run_q[i] && (pscCnt_q[i] >= psc_q[i]);
            if (run_q[i]) begin
                pscCnt_d[i] = tick[i] ? 8'd0 : pscCnt_q[i] + 8'd1;
            end
            if (chSel[i] && (regSel == REG_CONTROL)) begin
                psc_d[i] = s1.writedata[15:8];
                if (s1.writedata[CTRL_START]) begin
                    pscCnt_d[i] = 8'd0;
                end
            end
            if (chSel[i] && (regSel == REG_PERIOD)) begin
                pscCnt_d[i] = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                psc_q[i]    <= 8'd0;
                pscCnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                psc_q[i]    <= psc_d[i];
                pscCnt_q[i] <= pscCnt_d[i];
            end
        end
    end
`else
    // No prescaler: every clock is a tick while the channel runs
    always_comb begin
        tick = run_q;
        for (int i = 0; i < NUM_CH; i++) begin
            pscRd[i] = 8'd0;
        end
    end
`endif

    // Channel next-state. Bus writes are applied after the tick logic so a
    // PERIOD write or START/STOP overrides the counter's own update; SNAP
    // reads cnt_q and therefore sees the pre-decrement value.
    // Timeout is the rising edge of the registered counter==0 compare, so a
    // counter parked at 0 (PERIOD=0, or stopped at 0) raises TO only once.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ctrl_d[i]   = ctrl_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            snap_d[i]   = snap_q[i];
            run_d[i]    = run_q[i];
            zero_d[i]   = (cnt_q[i] == '0);
            timeout[i]  = (cnt_q[i] == '0) && !zero_q[i];
            // a timeout in the same cycle as a STATUS write keeps TO set
            to_d[i]     = timeout[i] ||
                          (to_q[i] && !(chSel[i] && (regSel == REG_STATUS)));

            if (tick[i]) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i] = period_q[i];
                    if (!ctrl_q[i][CTRL_CONT]) begin
                        run_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end

            if (chSel[i]) begin
                case (regSel)
                    REG_CONTROL: begin
                        ctrl_d[i] = s1.writedata[3:0];
                        if (s1.writedata[CTRL_START]) begin
                            run_d[i] = 1'b1;
                        end else if (s1.writedata[CTRL_STOP]) begin
                            run_d[i] = 1'b0;
                        end
                    end
                    REG_PERIOD: begin
                        period_d[i] = s1.writedata[CNT_W-1:0];
                        cnt_d[i]    = s1.writedata[CNT_W-1:0];
                        run_d[i]    = 1'b0;
                    end
                    REG_SNAP: begin
                        snap_d[i] = cnt_q[i];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read mux; out-of-range channels match no index and return 0
    always_comb begin
        readData_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chanValid && (chanIdx == 32'(i))) begin
                case (regSel)
                    REG_STATUS:  readData_d = {30'd0, run_q[i], to_q[i]};
                    REG_CONTROL: readData_d = {16'd0, pscRd[i], 4'd0, ctrl_q[i]};
                    REG_PERIOD:  readData_d = 32'(period_q[i]);
                    default:     readData_d = 32'(snap_q[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readData_q <= '0;
            to_q       <= '0;
            run_q      <= '0;
            zero_q     <= {NUM_CH{DEF_CNT == '0}};
            for (int i = 0; i < NUM_CH; i++) begin
                ctrl_q[i]   <= 4'd0;
                period_q[i] <= DEF_CNT;
                cnt_q[i]    <= DEF_CNT;
                snap_q[i]   <= '0;
            end
        end else begin
            readData_q <= readData_d;
            to_q       <= to_d;
            run_q      <= run_d;
            zero_q     <= zero_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ctrl_q[i]   <= ctrl_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                snap_q[i]   <= snap_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            irq[i] = to_q[i] && ctrl_q[i][CTRL_ITO];
        end
    end

    assign irq_any     = |irq;
    assign s1.readdata = readData_q;

endmodule

// File: tb/tb_soc_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_soc_multi_timer
// Self-checking bench for soc_multi_timer (NUM_CH=4, ADDR_W=5 so channels
// 4..7 are out of range). A register table checks reset values, readback and
// out-of-range decoding; hand-written sequences cover timing corner cases.
// Read expectations go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_soc_multi_timer;

    localparam int          NUM_CH     = 4;
    localparam int          ADDR_W     = 5;
    localparam logic [31:0] DEF_PERIOD = 32'h0001869F;

`ifdef SOC_MULTI_TIMER_PRESCALE_EN
    localparam int          PSC_FIRST  = 13;
    localparam int          PSC_PER    = 16;
    localparam logic [31:0] PSC_CTRL   = 32'h00000307;
    localparam logic [31:0] CTRL3_EXP  = 32'h0000FF03;
`else
    localparam int          PSC_FIRST  = 4;
    localparam int          PSC_PER    = 4;
    localparam logic [31:0] PSC_CTRL   = 32'h00000007;
    localparam logic [31:0] CTRL3_EXP  = 32'h00000003;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    soc_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

    soc_multi_timer #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (32),
        .DEFAULT_PERIOD(99999),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .s1     (bus),
        .irq    (irq),
        .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] expected;
    } exp_t;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [31:0]       data;
        logic [31:0]       expected;
    } vec_t;

    exp_t sbQueue[$];
    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkIrq(input string name, input logic [NUM_CH-1:0] exp);
        checkVal(name, 32'(irq), 32'(exp));
    endtask

    // One bus cycle, entered and left on a falling edge
    task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic wr, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = !wr;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
        end else begin
            e = sbQueue.pop_front();
            checkVal(e.name, bus.readdata, e.expected);
        end
    endtask

    task automatic doRead(input logic [ADDR_W-1:0] a, input string name, input logic [31:0] exp);
        exp_t e;
        e.name     = name;
        e.expected = exp;
        sbQueue.push_back(e);
        applyStimulus(a, 1'b0, 32'h0);
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic addVec(input string name, input logic [ADDR_W-1:0] a, input logic wr,
                          input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.name     = name;
        v.addr     = a;
        v.wr       = wr;
        v.data     = d;
        v.expected = exp;
        vecs.push_back(v);
    endtask

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        reset_n        = 1'b0;

        addVec("rst_period0",   5'h02, 1'b0, 32'h0,        DEF_PERIOD);
        addVec("rst_status0",   5'h00, 1'b0, 32'h0,        32'h0);
        addVec("rst_control0",  5'h01, 1'b0, 32'h0,        32'h0);
        addVec("rst_snap0",     5'h03, 1'b0, 32'h0,        32'h0);
        addVec("rst_period1",   5'h06, 1'b0, 32'h0,        DEF_PERIOD);
        addVec("wr_period1",    5'h06, 1'b1, 32'hA5A51234, 32'h0);
        addVec("period1_rb",    5'h06, 1'b0, 32'h0,        32'hA5A51234);
        addVec("wr_oob_period", 5'h16, 1'b1, 32'h00000055, 32'h0);
        addVec("oob_read",      5'h16, 1'b0, 32'h0,        32'h0);
        addVec("oob_no_alias",  5'h06, 1'b0, 32'h0,        32'hA5A51234);
        addVec("wr_ctrl3",      5'h0D, 1'b1, 32'h0000FF03, 32'h0);
        addVec("ctrl3_rb",      5'h0D, 1'b0, 32'h0,        CTRL3_EXP);
        addVec("status3_idle",  5'h0C, 1'b0, 32'h0,        32'h0);
        addVec("wr_snap0",      5'h03, 1'b1, 32'h0,        32'h0);
        addVec("snap0_idle",    5'h03, 1'b0, 32'h0,        DEF_PERIOD);
        addVec("wr_ctrl3_clr",  5'h0D, 1'b1, 32'h0,        32'h0);

        repeat (3) @(negedge clk);
        checkVal("reset_readdata", bus.readdata, 32'h0);
        checkIrq("reset_irq", '0);
        checkVal("reset_irq_any", 32'(irq_any), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                applyStimulus(vecs[i].addr, 1'b1, vecs[i].data);
            end else begin
                doRead(vecs[i].addr, vecs[i].name, vecs[i].expected);
            end
        end

        // ch1 continuous, PERIOD=9: TO every 10 clocks, STATUS write clears
        applyStimulus(5'h06, 1'b1, 32'd9);
        applyStimulus(5'h05, 1'b1, 32'h7);
        idle(9);
        checkIrq("ch1_before_to", 4'b0000);
        idle(1);
        checkIrq("ch1_to", 4'b0010);
        checkVal("ch1_irq_any", 32'(irq_any), 32'h1);
        applyStimulus(5'h04, 1'b1, 32'h0);
        checkIrq("ch1_cleared", 4'b0000);
        idle(8);
        checkIrq("ch1_before_2nd", 4'b0000);
        idle(1);
        checkIrq("ch1_2nd_to", 4'b0010);
        applyStimulus(5'h05, 1'b1, 32'h8);
        applyStimulus(5'h04, 1'b1, 32'h0);
        checkIrq("ch1_stopped", 4'b0000);

        // ch2 one-shot, PERIOD=4: TO after 5 clocks, RUN clears, counter=4
        applyStimulus(5'h0A, 1'b1, 32'd4);
        applyStimulus(5'h09, 1'b1, 32'h5);
        idle(4);
        checkIrq("ch2_before_to", 4'b0000);
        idle(1);
        checkIrq("ch2_to", 4'b0100);
        doRead(5'h08, "ch2_status_oneshot", 32'h1);
        idle(3);
        applyStimulus(5'h0B, 1'b1, 32'h0);
        doRead(5'h0B, "ch2_snap_hold", 32'd4);
        applyStimulus(5'h08, 1'b1, 32'h0);

        // ch0 PERIOD=20 running: snapshot, stop/hold, period reload
        applyStimulus(5'h02, 1'b1, 32'd20);
        applyStimulus(5'h01, 1'b1, 32'h6);
        idle(3);
        applyStimulus(5'h03, 1'b1, 32'h0);
        doRead(5'h03, "ch0_snap_running", 32'd17);
        applyStimulus(5'h01, 1'b1, 32'h8);
        idle(10);
        applyStimulus(5'h03, 1'b1, 32'h0);
        doRead(5'h03, "ch0_snap_stopped", 32'd14);
        doRead(5'h01, "ch0_ctrl_rb", 32'h8);
        doRead(5'h00, "ch0_status_stopped", 32'h0);
        applyStimulus(5'h02, 1'b1, 32'd3);
        applyStimulus(5'h03, 1'b1, 32'h0);
        doRead(5'h03, "ch0_snap_new_period", 32'd3);

        // ch3 PERIOD=2: STATUS write on the timeout cycle keeps TO
        applyStimulus(5'h0E, 1'b1, 32'd2);
        applyStimulus(5'h0D, 1'b1, 32'h7);
        idle(3);
        checkIrq("ch3_first_to", 4'b1000);
        applyStimulus(5'h0C, 1'b1, 32'h0);
        checkIrq("ch3_cleared", 4'b0000);
        idle(1);
        checkIrq("ch3_still_clear", 4'b0000);
        applyStimulus(5'h0C, 1'b1, 32'h0);
        checkIrq("ch3_collision_to_wins", 4'b1000);
        applyStimulus(5'h0D, 1'b1, 32'h8);
        applyStimulus(5'h0C, 1'b1, 32'h0);
        doRead(5'h0C, "ch3_status_stopped", 32'h0);
        applyStimulus(5'h0D, 1'b1, 32'hC);
        doRead(5'h0C, "ch3_status_start_stop", 32'h2);
        doRead(5'h0D, "ch3_ctrl_rb", 32'hC);

        // ch2 PERIOD=3 with PRESCALE=3 (ignored without the prescaler)
        applyStimulus(5'h0A, 1'b1, 32'd3);
        applyStimulus(5'h09, 1'b1, 32'h0307);
        idle(PSC_FIRST - 1);
        checkIrq("psc_before_to", 4'b0000);
        idle(1);
        checkIrq("psc_first_to", 4'b0100);
        applyStimulus(5'h08, 1'b1, 32'h0);
        idle(PSC_PER - 2);
        checkIrq("psc_before_2nd", 4'b0000);
        idle(1);
        checkIrq("psc_2nd_to", 4'b0100);
        doRead(5'h09, "psc_ctrl_rb", PSC_CTRL);
        applyStimulus(5'h0A, 1'b1, 32'd5);
        doRead(5'h08, "period_write_stops_run", 32'h1);
        idle(3);
        applyStimulus(5'h0B, 1'b1, 32'h0);
        doRead(5'h0B, "period_write_reload", 32'd5);

        // asynchronous reset in the middle of a cycle
        checkIrq("pre_reset_irq", 4'b0100);
        #2 reset_n = 1'b0;
        #1;
        checkVal("async_reset_readdata", bus.readdata, 32'h0);
        checkIrq("async_reset_irq", 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        doRead(5'h08, "post_reset_status2", 32'h0);
        doRead(5'h0A, "post_reset_period2", DEF_PERIOD);
        doRead(5'h09, "post_reset_ctrl2", 32'h0);
        idle(4);
        doRead(5'h0C, "post_reset_status3", 32'h0);
        checkIrq("post_reset_irq", 4'b0000);

        if (sbQueue.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending, expected 0", sbQueue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/soc_multi_timer.md
Name: soc_multi_timer

Overview:
- Parametrised multi-channel interval timer on the SoC Avalon-MM bus, one slave port (s1) shared by NUM_CH independent down-counters.
- Each channel has a period, one-shot/continuous mode, software start/stop, snapshot and its own interrupt; a global irq_any is provided for a single CPU IRQ line.
- Replaces single-channel 16-bit-bus timers: 32-bit bus, configurable counter width, event-safe status clear.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CNT_W, 32, counter/period width in bits (8..32)
DEFAULT_PERIOD, 99999, reset value of every channel's period and counter (truncated to CNT_W)
ADDR_W, 4, address width; must be >= clog2(NUM_CH)+2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address: [ADDR_W-1:2]=channel, [1:0]=register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  NUM_CH  per-channel interrupt
irq_any  out  1  OR of irq

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. During reset: readdata=0, irq=0, irq_any=0. Per channel: CONTROL=0, TO=0, RUN=0, PERIOD=DEFAULT_PERIOD, counter=DEFAULT_PERIOD, SNAP=0.
- Register map per channel (reg = address[1:0]):
  - 0 STATUS: read {30'b0, RUN, TO}; any write clears TO.
  - 1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bit2 START, bit3 STOP. Write stores bits[3:0]; START/STOP are one-cycle command strobes but also read back as last written.
  - 2 PERIOD: write sets period (writedata[CNT_W-1:0]); read zero-extended.
  - 3 SNAP: any write captures the counter; read returns the snapshot zero-extended.
- Channel index >= NUM_CH: writes ignored, reads return 0.
- Reads: readdata registered from the current address every clock, 1-cycle latency. Read has no side effects.
- Counter, per enabled tick (every clk; see optional feature):
  - If RUN and counter!=0: decrement.
  - If RUN and counter==0: reload from PERIOD. The interval is PERIOD+1 ticks.
  - If CONT=0, RUN clears on the same tick as the reload.
- Timeout: TO sets on the cycle the counter transitions to 0 (edge of counter==0, registered compare). It does not re-set while the counter is held at 0.
- irq[i] = TO[i] & ITO[i], combinational from registers; irq_any = |irq.
- START sets RUN next cycle; the counter continues from its current value.
- STOP clears RUN; the counter holds.
- START and STOP written together: START wins.
- PERIOD write: next cycle counter <= new PERIOD and RUN <= 0 (force reload). A START in a later write resumes from the new period.
- PERIOD=0 in continuous mode: TO sets once, the counter sits at 0, no further edges.
- Simultaneous STATUS write and timeout event on the same channel: timeout wins, TO stays 1 (no lost events).
- Simultaneous SNAP write and decrement: the snapshot takes the pre-decrement value.
- Reset mid-count: all state returns to reset values asynchronously; RUN=0 after release.

Optional Feature:
- Macro: SOC_MULTI_TIMER_PRESCALE_EN.
- Defined:
  - CONTROL bits[15:8] = PRESCALE (stored, readable).
  - Each channel has an 8-bit prescale counter that runs while RUN=1.
  - A tick is enabled once every PRESCALE+1 clocks, so interval = (PERIOD+1)*(PRESCALE+1) clocks.
  - The prescale counter clears on START, on PERIOD write and on reset.
- Not defined: bits[15:8] are ignored on write and read 0; a tick is enabled every clock.

Test Plan:
- Reset, then read ch0 PERIOD, STATUS and CONTROL -> readdata 0x0001869F, 0x0, 0x0; irq=0.
- ch1: write PERIOD=9, CONTROL=0x7 (ITO|CONT|START) -> TO sets and irq[1]=1 every 10 clocks; irq_any=1; write STATUS -> irq[1] drops next cycle; other irq bits stay 0.
- ch2: PERIOD=4, CONTROL=0x5 (one-shot) -> after 5 clocks TO=1, RUN=0, counter=4 and holds; STATUS reads 0x1.
- ch0 running with PERIOD=20: write SNAP, then read SNAP -> value equals counter at the write cycle. Write CONTROL=0x8 -> counter frozen across 10 clocks. Write PERIOD=3 -> counter=3, RUN=0.
- ch3 PERIOD=2 continuous: issue a STATUS write on the exact cycle the counter hits 0 -> TO remains 1. Also write CONTROL=0xC -> RUN=1.
- With SOC_MULTI_TIMER_PRESCALE_EN: PERIOD=3, CONTROL=0x0306 -> TO every 16 clocks. Without the macro, the same write -> TO every 4 clocks and CONTROL reads 0x6.
